carros_datapath: RTL and testbench
==================================

# carros_datapath

Datapath stage directly downstream of the car-drawing control FSM. It consumes the FSM strobes (load X/Y, add, jump, paint) and holds the car's on-screen position. It walks a sprite raster of ANCHO×ALTO pixels and emits pixel coordinates plus a write strobe to the frame-drawing logic. It returns the end-of-row and end-of-sprite flags to the FSM, and advances the car horizontally once per frame tick.

## Interface
- ANCHO, 32: sprite width in pixels (≥2).
- ALTO, 16: sprite height in pixels (≥1).
- X_MAX, 639: last visible column.
- X_INICIAL, 607: car X after reset and wrap target.
- Y_CARRIL, 200: fixed lane Y of the car.
- VEL, 2: pixels moved left per frame tick (1..ANCHO).
- COLOR, 8'hE0: pixel colour emitted.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iEnableX  in  1  load strobe for the column counter and base X, from the FSM.
- iEnableY  in  1  load strobe for row/base Y (with iEnableX), or row advance (with iSalta), from the FSM.
- iSuma  in  1  column increment / pixel write, from the FSM.
- iSalta  in  1  next-row strobe, from the FSM.
- iPintar  in  1  FSM is in a painting state.
- iFrameTick  in  1  one-cycle pulse per frame.
- iJugX  in  10  player box X (collision only).
- iJugY  in  9  player box Y (collision only).
- oEnableCero  out  1  current row finished; drives the FSM's iEnableCero input.
- oResetPintar  out  1  sprite finished; drives the FSM's iResetPintar input.
- oPixX  out  10  pixel column.
- oPixY  out  9  pixel row.
- oWe  out  1  pixel write strobe.
- oColor  out  8  pixel colour.
- oChoque  out  1  sticky collision flag.

## Operation
- Registers:
  - carX (10b): reset X_INICIAL.
  - baseX (10b): reset 0.
  - baseY (9b): reset 0.
  - col (ceil(log2(ANCHO+1))b): reset 0.
  - row (ceil(log2(ALTO))b): reset 0.
  - tickPend: reset 0.
  - oChoque: reset 0.
- Load (iEnableX & iEnableY & !iSalta): baseX<=carX, baseY<=Y_CARRIL, col<=0, row<=0.
- Add (iSuma): col<=col+1. Outputs are combinational from the current registers: oWe=iPintar&iSuma, oPixX=baseX+col, oPixY=baseY+row. The write therefore uses the pre-increment column.
- Jump (iSalta & iEnableY): col<=0, row<=row+1. If row==ALTO-1, row holds.
- oEnableCero = (col==ANCHO), combinational.
- oResetPintar = iPintar & (col==ANCHO) & (row==ALTO-1), combinational. It is gated by iPintar so it never holds the FSM in idle.
- Movement, on iFrameTick with !iPintar:
  - carX<=carX-VEL.
  - If carX<VEL, carX<=X_INICIAL (wrap).
- Tick while iPintar=1: set tickPend. Apply the move on the first cycle with iPintar=0, then clear tickPend.
- Tick arriving in the same cycle a pending move is applied: the two coalesce into one move.
- oPixX is not clipped. Pixels with oPixX>X_MAX still assert oWe; the downstream writer discards them.
- oColor=COLOR constant.
- Simultaneous load and jump cannot come from the FSM. If they occur anyway, jump wins.

## Timing
- All register updates happen on the rising edge of iClk.
- All flags are combinational, so the FSM sees them in the same cycle.
- Per row, the FSM sequence is add/check: ANCHO writes, then one jump cycle.
- Full sprite latency from load: 1 + ALTO×(2×ANCHO) + (ALTO−1) cycles until oResetPintar.
- The first write occurs 1 cycle after the load cycle.
- Reset mid-sprite: all registers return to reset values on the next edge, and oWe drops immediately since iPintar falls with the FSM reset.

## Configuration
- CARROS_COLISION_EN defined:
  - On every applied movement, oChoque<=oChoque | overlap(carX,Y_CARRIL,iJugX,iJugY), with both boxes ANCHO×ALTO.
  - overlap = |Δx|<ANCHO & |Δy|<ALTO.
  - Evaluated with the pre-move carX.
  - Cleared only by iReset.
- Undefined: oChoque is tied 0. The iJugX/iJugY ports remain and are ignored.

## Structure
- Package carros_pkg holds:
  - Width constants: X_W=10, Y_W=9.
  - Defaults for ANCHO/ALTO/X_MAX.
  - The collision-overlap function prototype.
- Sub-module carros_colision: combinational box-overlap comparator (two boxes in, 1b out), instantiated only under CARROS_COLISION_EN.

## Test plan
- Reset, then load with ANCHO=4, ALTO=2, carX=100: first row writes (100,200)..(103,200). oEnableCero=1 when col=4. After the jump, row 2 writes (100,201)..(103,201).
- Full-sprite run with ANCHO=4, ALTO=2: oResetPintar pulses in the check cycle after the 8th write. No further oWe until the next load.
- iFrameTick while idle with carX=607, VEL=2: carX=605. Repeat from carX=1: wraps to 607.
- iFrameTick during painting: carX is unchanged until iPintar falls, then decrements exactly once. Two ticks during one sprite still give a single move.
- iReset asserted mid-row (col=2): on the next edge, col=0, row=0, carX=X_INICIAL, oChoque=0.
- CARROS_COLISION_EN, with iJugX=carX+10, iJugY=205 at a tick: oChoque=1 and stays 1. With iJugX=carX+40: stays 0.

Source files
------------

// File: rtl/carros_pkg.sv
// Shared widths, parameter defaults and the box-overlap helper for the car datapath.
package carros_pkg;

  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned ANCHO_DEF = 32;
  localparam int unsigned ALTO_DEF  = 16;
  localparam int unsigned X_MAX_DEF = 639;

  // Two ANCHO x ALTO boxes overlap when both axis distances are below the box size.
  function automatic logic boxes_overlap(
    input logic [X_W-1:0] ax,
    input logic [Y_W-1:0] ay,
    input logic [X_W-1:0] bx,
    input logic [Y_W-1:0] by,
    input int unsigned    ancho,
    input int unsigned    alto
  );
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    return (32'(dx) < ancho) && (32'(dy) < alto);
  endfunction

endpackage

// File: rtl/carros_datapath_colision.sv
// Combinational overlap comparator between the car box and the player box.
module carros_colision
  import carros_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF,
  parameter int unsigned ALTO  = ALTO_DEF
) (
  input  logic [X_W-1:0] a_x,
  input  logic [Y_W-1:0] a_y,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  output logic           overlap_c
);

  assign overlap_c = boxes_overlap(a_x, a_y, b_x, b_y, ANCHO, ALTO);

endmodule

// File: rtl/carros_datapath.sv
// Car sprite raster walker and horizontal mover behind the car-drawing FSM.
// Optional collision detection is enabled with `define CARROS_COLISION_EN.
module carros_datapath
  import carros_pkg::*;
#(
  parameter int unsigned ANCHO     = ANCHO_DEF,
  parameter int unsigned ALTO      = ALTO_DEF,
  parameter int unsigned X_MAX     = X_MAX_DEF,
  parameter int unsigned X_INICIAL = 607,
  parameter int unsigned Y_CARRIL  = 200,
  parameter int unsigned VEL       = 2,
  parameter logic [7:0]  COLOR     = 8'hE0
) (
  input  logic           iClk,
  input  logic           iReset,
  input  logic           iEnableX,
  input  logic           iEnableY,
  input  logic           iSuma,
  input  logic           iSalta,
  input  logic           iPintar,
  input  logic           iFrameTick,
  input  logic [X_W-1:0] iJugX,
  input  logic [Y_W-1:0] iJugY,
  output logic           oEnableCero,
  output logic           oResetPintar,
  output logic [X_W-1:0] oPixX,
  output logic [Y_W-1:0] oPixY,
  output logic           oWe,
  output logic [7:0]     oColor,
  output logic           oChoque
);

  localparam int unsigned COL_W = $clog2(ANCHO + 1);
  localparam int unsigned ROW_W = (ALTO > 1) ? $clog2(ALTO) : 1;

  logic [X_W-1:0]   car_x;
  logic [X_W-1:0]   base_x;
  logic [Y_W-1:0]   base_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             tick_pend;

  logic load_c;
  logic jump_c;
  logic move_c;
  logic col_end_c;
  logic row_last_c;

  assign load_c     = iEnableX & iEnableY & ~iSalta;
  assign jump_c     = iSalta & iEnableY;
  assign move_c     = ~iPintar & (iFrameTick | tick_pend);
  assign col_end_c  = (col == COL_W'(ANCHO));
  assign row_last_c = (row == ROW_W'(ALTO - 1));

  // Raster position; jump has priority so a stray load+jump still advances the row.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      base_x <= '0;
      base_y <= '0;
      col    <= '0;
      row    <= '0;
    end else if (jump_c) begin
      col <= '0;
      if (!row_last_c) row <= row + ROW_W'(1);
    end else if (load_c) begin
      base_x <= car_x;
      base_y <= Y_W'(Y_CARRIL);
      col    <= '0;
      row    <= '0;
    end else if (iSuma) begin
      col <= col + COL_W'(1);
    end
  end

  // Ticks seen while painting are held and coalesce into a single move once idle.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      car_x     <= X_W'(X_INICIAL);
      tick_pend <= 1'b0;
    end else begin
      tick_pend <= iPintar & (tick_pend | iFrameTick);
      if (move_c) begin
        car_x <= (car_x < X_W'(VEL)) ? X_W'(X_INICIAL) : (car_x - X_W'(VEL));
      end
    end
  end

  assign oPixX        = base_x + X_W'(col);
  assign oPixY        = base_y + Y_W'(row);
  assign oWe          = iPintar & iSuma;
  assign oColor       = COLOR;
  assign oEnableCero  = col_end_c;
  assign oResetPintar = iPintar & col_end_c & row_last_c;

  // Off-screen columns pass through; the frame writer clips against X_MAX.
  logic unused_fuera;
  assign unused_fuera = (oPixX > X_W'(X_MAX));

`ifdef CARROS_COLISION_EN
  logic hit_c;

  carros_colision #(
    .ANCHO(ANCHO),
    .ALTO (ALTO)
  ) u_colision (
    .a_x      (car_x),
    .a_y      (Y_W'(Y_CARRIL)),
    .b_x      (iJugX),
    .b_y      (iJugY),
    .overlap_c(hit_c)
  );

  // Sticky hit, sampled against the pre-move position on each applied move.
  always_ff @(posedge iClk) begin
    if (iReset) oChoque <= 1'b0;
    else if (move_c) oChoque <= oChoque | hit_c;
  end
`else
  logic unused_jug;
  assign unused_jug = ^{iJugX, iJugY};
  assign oChoque    = 1'b0;
`endif

endmodule

// File: tb/tb_carros_datapath.sv
// Directed self-checking bench for carros_datapath with a 4x2 sprite.
module tb_carros_datapath;

  localparam int unsigned ANCHO = 4;
  localparam int unsigned ALTO  = 2;
`ifdef CARROS_COLISION_EN
  localparam logic COL_EN = 1'b1;
`else
  localparam logic COL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ex, ey, suma, salta, pintar, tick;
  logic [9:0] jug_x;
  logic [8:0] jug_y;
  logic       enable_cero, reset_pintar, we, choque;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] color;

  int vectors = 0;
  int miscompares = 0;

  carros_datapath #(.ANCHO(ANCHO), .ALTO(ALTO)) dut (
    .iClk(clk), .iReset(rst), .iEnableX(ex), .iEnableY(ey), .iSuma(suma),
    .iSalta(salta), .iPintar(pintar), .iFrameTick(tick), .iJugX(jug_x), .iJugY(jug_y),
    .oEnableCero(enable_cero), .oResetPintar(reset_pintar), .oPixX(pix_x), .oPixY(pix_y),
    .oWe(we), .oColor(color), .oChoque(choque)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex = 0; ey = 0; suma = 0; salta = 0; tick = 0;
  endtask

  task automatic load();
    ex = 1; ey = 1;
    cyc();
    ex = 0; ey = 0;
    #1;
  endtask

  task automatic frame_tick();
    tick = 1;
    cyc();
    tick = 0;
    #1;
  endtask

  // Load, then walk the full sprite the way the FSM does: add/check per pixel, jump per row.
  task automatic draw_sprite(input int x0);
    load();
    for (int r = 0; r < int'(ALTO); r++) begin
      for (int c = 0; c < int'(ANCHO); c++) begin
        pintar = 1; suma = 1; #1;
        chk("we_add", we, 1);
        chk("pix_x", pix_x, x0 + c);
        chk("pix_y", pix_y, 200 + r);
        chk("cero_add", enable_cero, 0);
        cyc();
        suma = 0; #1;
        chk("we_check", we, 0);
        chk("cero_check", enable_cero, (c == int'(ANCHO) - 1) ? 1 : 0);
        chk("reset_pintar", reset_pintar, (c == int'(ANCHO) - 1 && r == int'(ALTO) - 1) ? 1 : 0);
        cyc();
      end
      if (r < int'(ALTO) - 1) begin
        salta = 1; ey = 1;
        cyc();
        salta = 0; ey = 0; #1;
      end
    end
  endtask

  initial begin
    rst = 1; pintar = 0; jug_x = '0; jug_y = '0;
    idle();
    cyc(); cyc();
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_we", we, 0);
    chk("rst_cero", enable_cero, 0);
    chk("rst_reset_pintar", reset_pintar, 0);
    chk("rst_choque", choque, 0);
    chk("color", color, 8'hE0);
    rst = 0;

    // Full sprite at X_INICIAL, then an extra jump on the last row holds the row.
    draw_sprite(607);
    salta = 1; ey = 1; pintar = 1;
    cyc();
    idle(); #1;
    chk("last_row_hold_y", pix_y, 201);
    chk("last_row_hold_x", pix_x, 607);
    chk("last_row_cero", enable_cero, 0);
    pintar = 0; #1;
    chk("idle_reset_pintar", reset_pintar, 0);
    chk("idle_we", we, 0);

    // Idle tick moves left by VEL.
    frame_tick();
    load();
    chk("tick_idle_x", pix_x, 605);
    chk("load_y", pix_y, 200);

    // Collision: pre-move distance decides; hit is sticky.
    jug_x = 10'd600; jug_y = 9'd201;
    frame_tick();
    chk("choque_premove", choque, 0);
    jug_x = 10'd605; jug_y = 9'd201;
    frame_tick();
    chk("choque_hit", choque, 32'(COL_EN));
    jug_x = 10'd0; jug_y = 9'd0;
    frame_tick();
    chk("choque_sticky", choque, 32'(COL_EN));
    load();
    chk("after_coll_x", pix_x, 599);
    rst = 1;
    cyc();
    rst = 0; #1;
    chk("choque_cleared", choque, 0);
    load();
    chk("reset_car_x", pix_x, 607);

    // Two ticks while painting give one deferred move.
    pintar = 1;
    frame_tick();
    cyc();
    frame_tick();
    load();
    chk("paint_hold_x", pix_x, 607);
    pintar = 0;
    cyc();
    load();
    chk("paint_deferred_x", pix_x, 605);
    cyc(); cyc();
    load();
    chk("paint_single_move", pix_x, 605);

    // Pending tick plus a new tick on the release cycle coalesce.
    pintar = 1;
    frame_tick();
    pintar = 0;
    frame_tick();
    cyc();
    load();
    chk("coalesce_x", pix_x, 603);

    // Walk down to carX=1, then wrap.
    for (int i = 0; i < 301; i++) frame_tick();
    load();
    chk("min_x", pix_x, 1);
    frame_tick();
    load();
    chk("wrap_x", pix_x, 607);

    // Reset mid-row at col=2.
    pintar = 1; suma = 1;
    cyc(); cyc();
    #1;
    chk("mid_row_x", pix_x, 609);
    rst = 1; pintar = 0; idle();
    cyc();
    rst = 0; #1;
    chk("midrst_pix_x", pix_x, 0);
    chk("midrst_pix_y", pix_y, 0);
    chk("midrst_we", we, 0);
    chk("midrst_choque", choque, 0);
    load();
    chk("midrst_car_x", pix_x, 607);

    // Load and jump together: jump wins.
    suma = 1;
    cyc();
    suma = 0; ex = 1; ey = 1; salta = 1;
    cyc();
    idle(); #1;
    chk("jump_wins_y", pix_y, 201);
    chk("jump_wins_x", pix_x, 607);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
